npc_pc_ras: RTL and testbench

- Fetch-side program-counter unit for the 5-stage MIPS pipeline. Owns the F-stage PC register and computes next-PC from the D-stage control-flow decision.
- Adds a parametrised return-address stack (RAS). `jr $ra` can then redirect without waiting for a forwarded register value.
- Verifies each prediction against the resolved value later in the pipeline and redirects on mismatch.
- Also handles exception-vector and eret redirects.

---
 rtl/npc_pc_ras_pkg.sv | 9 +
 rtl/ras_stack.sv | 40 ++++
 rtl/npc_pc_ras.sv | 71 +++++++
 tb/tb_npc_pc_ras.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/npc_pc_ras_pkg.sv
// npc_pc_ras_pkg: next-PC select codes and default reset/exception addresses
package npc_pc_ras_pkg;
    localparam logic [1:0] NPC_order  = 2'd0;
    localparam logic [1:0] NPC_branch = 2'd1;
    localparam logic [1:0] NPC_jump   = 2'd2;
    localparam logic [1:0] NPC_reg    = 2'd3;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack, push overwrites the oldest entry when full
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   push_data,
    output logic [31:0]   top,
    output logic [PW:0]   count
);
    logic [31:0] mem [DEPTH];
    logic [PW-1:0] tp, base;
    logic eff_pop;
    logic [PW:0] cnt_after;
    always_comb begin
        eff_pop   = pop & (count != '0);
        base      = tp - PW'(eff_pop);
        cnt_after = count - (PW+1)'(eff_pop);
        top       = mem[tp];
    end
    // pop-then-push lands on the popped slot, so a same-cycle call/return replaces the top
    always_ff @(posedge clk) begin
        if (reset) begin
            tp    <= '0;
            count <= '0;
        end else if (push) begin
            tp    <= base + 1'b1;
            count <= (cnt_after == (PW+1)'(DEPTH)) ? cnt_after : cnt_after + 1'b1;
        end else if (eff_pop) begin
            tp    <= base;
            count <= cnt_after;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && push) mem[base + 1'b1] <= push_data;
    end
endmodule

// File: rtl/npc_pc_ras.sv
// npc_pc_ras: fetch PC register and next-PC mux with return-address prediction
module npc_pc_ras
    import npc_pc_ras_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
    parameter int          RAS_DEPTH = 4,
    parameter int          RAS_PTR_W = $clog2(RAS_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [31:0]          pc_d,
    input  logic [25:0]          imm26,
    input  logic [31:0]          ra,
    input  logic                 ra_ready,
    input  logic [1:0]           npc_op,
    input  logic                 is_call,
    input  logic                 is_ret,
    input  logic                 resolve_valid,
    input  logic [31:0]          resolve_target,
    input  logic                 exc_req,
    input  logic                 eret_req,
    input  logic [31:0]          epc,
    output logic [31:0]          pc_f,
    output logic [31:0]          npc,
    output logic                 ret_pred,
    output logic                 ret_stall,
    output logic                 mispredict,
    output logic [RAS_PTR_W:0]   ras_count
);
    logic [31:0] ras_top, pend_target, target, br_off;
    logic pend_valid, is_reg_ret, ras_empty, accepted;
    always_comb begin
        is_reg_ret = (npc_op == NPC_reg) & is_ret;
        ras_empty  = ras_count == '0;
        br_off     = {{14{imm26[15]}}, imm26[15:0], 2'b00};
        mispredict = !reset & resolve_valid & pend_valid & (resolve_target != pend_target);
        // only one prediction may be in flight; otherwise wait for the forwarded value
        ret_stall  = !reset & is_reg_ret & !ra_ready & (ras_empty | pend_valid);
        ret_pred   = !reset & is_reg_ret & !ra_ready & !ras_empty & !pend_valid;
        accepted   = !reset & !stall & !ret_stall & !exc_req & !mispredict;
        target = (npc_op == NPC_order)  ? pc_f + 32'd4 :
                 (npc_op == NPC_branch) ? pc_d + 32'd4 + br_off :
                 (npc_op == NPC_jump)   ? {pc_d[31:28], imm26, 2'b00} :
                 ret_pred               ? ras_top : ra;
        npc = reset                 ? RESET_PC :
              exc_req               ? EXC_VEC :
              mispredict            ? resolve_target :
              eret_req              ? epc :
              (stall | ret_stall)   ? pc_f : target;
    end
    ras_stack #(.DEPTH(RAS_DEPTH), .PW(RAS_PTR_W)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (accepted & is_call),
        .pop       (accepted & is_reg_ret),
        .push_data (pc_d + 32'd8),
        .top       (ras_top),
        .count     (ras_count)
    );
    always_ff @(posedge clk) begin
        pc_f <= npc;
        if (reset || exc_req || resolve_valid) begin
            pend_valid <= 1'b0;
        end else if (accepted && ret_pred) begin
            pend_valid  <= 1'b1;
            pend_target <= ras_top;
        end
    end
endmodule

// File: tb/tb_npc_pc_ras.sv
// tb_npc_pc_ras: directed vectors checked against a queue-based model every cycle
module tb_npc_pc_ras;
    logic clk = 0, reset, stall, ra_ready, is_call, is_ret, resolve_valid, exc_req, eret_req;
    logic [31:0] pc_d, ra, resolve_target, epc, pc_f, npc;
    logic [25:0] imm26;
    logic [1:0] npc_op;
    logic ret_pred, ret_stall, mispredict;
    logic [2:0] ras_count;
    int checks = 0, errors = 0;

    npc_pc_ras dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_d(pc_d), .imm26(imm26), .ra(ra),
        .ra_ready(ra_ready), .npc_op(npc_op), .is_call(is_call), .is_ret(is_ret),
        .resolve_valid(resolve_valid), .resolve_target(resolve_target), .exc_req(exc_req),
        .eret_req(eret_req), .epc(epc), .pc_f(pc_f), .npc(npc), .ret_pred(ret_pred),
        .ret_stall(ret_stall), .mispredict(mispredict), .ras_count(ras_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // model state: the RAS is a queue with the top at the back
    logic [31:0] m_ras[$];
    logic [31:0] m_pc, m_pend_t, e_top, e_off, e_tgt, e_npc;
    bit m_pend, started = 0;
    bit e_ret, e_empty, e_mis, e_rs, e_rp, e_acc;

    function void model_eval();
        e_ret   = npc_op == 2'd3 && is_ret;
        e_empty = m_ras.size() == 0;
        e_top   = e_empty ? 32'h0 : m_ras[$];
        e_mis   = !reset && resolve_valid && m_pend && resolve_target != m_pend_t;
        e_rs    = !reset && e_ret && !ra_ready && (e_empty || m_pend);
        e_rp    = !reset && e_ret && !ra_ready && !e_empty && !m_pend;
        e_off   = {{16{imm26[15]}}, imm26[15:0]};
        case (npc_op)
            2'd0: e_tgt = m_pc + 4;
            2'd1: e_tgt = pc_d + 4 + e_off * 4;
            2'd2: e_tgt = {pc_d[31:28], imm26, 2'b00};
            default: e_tgt = e_rp ? e_top : ra;
        endcase
        if (reset) e_npc = 32'h3000;
        else if (exc_req) e_npc = 32'h4180;
        else if (e_mis) e_npc = resolve_target;
        else if (eret_req) e_npc = epc;
        else if (stall || e_rs) e_npc = m_pc;
        else e_npc = e_tgt;
        e_acc = !reset && !stall && !e_rs && !exc_req && !e_mis;
    endfunction

    // inputs only change just after posedge, so the negedge view is what the next edge sees
    always @(negedge clk) begin
        model_eval();
        if (started) begin
            chk("pc_f", pc_f, m_pc);
            chk("npc", npc, e_npc);
            chk("ret_pred", 32'(ret_pred), 32'(e_rp));
            chk("ret_stall", 32'(ret_stall), 32'(e_rs));
            chk("mispredict", 32'(mispredict), 32'(e_mis));
            chk("ras_count", 32'(ras_count), 32'(m_ras.size()));
        end
        if (reset) begin
            m_ras.delete();
            m_pend  = 0;
            started = 1;
        end else begin
            if (e_acc) begin
                if (e_ret && !e_empty) void'(m_ras.pop_back());
                if (is_call) begin
                    m_ras.push_back(pc_d + 8);
                    if (m_ras.size() > 4) void'(m_ras.pop_front());
                end
            end
            if (exc_req || resolve_valid) m_pend = 0;
            else if (e_acc && e_rp) begin
                m_pend   = 1;
                m_pend_t = e_top;
            end
        end
        m_pc = e_npc;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {stall, ra_ready, is_call, is_ret, resolve_valid, exc_req, eret_req} = '0;
        npc_op = 2'd0;
        pc_d = 0; imm26 = 0; ra = 0; resolve_target = 0; epc = 0;
    endtask

    task automatic call(input logic [31:0] at);
        idle(); npc_op = 2'd2; is_call = 1; pc_d = at;
        tick();
    endtask

    task automatic ret(input logic rdy, input logic [31:0] rv);
        idle(); npc_op = 2'd3; is_ret = 1; ra_ready = rdy; ra = rv;
    endtask

    task automatic resolve(input logic [31:0] t);
        idle(); resolve_valid = 1; resolve_target = t;
    endtask

    initial begin
        idle();
        reset = 1;
        ret(0, 0);
        tick(); tick();
        chk("reset pc_f", pc_f, 32'h3000);
        chk("reset count", 32'(ras_count), 0);
        chk("reset ret_stall", 32'(ret_stall), 0);
        chk("reset ret_pred", 32'(ret_pred), 0);
        idle(); reset = 0;
        #1 chk("run pc0", pc_f, 32'h3000);
        tick(); chk("run pc1", pc_f, 32'h3004);
        tick(); chk("run pc2", pc_f, 32'h3008);
        npc_op = 2'd1; pc_d = 32'h3010; imm26 = 26'h000FFFE;
        #1 chk("branch npc", npc, 32'h300C);
        tick();
        npc_op = 2'd2; imm26 = 26'h0000C04;
        #1 chk("jump npc", npc, 32'h0000_3010);
        tick();
        // predicted return, confirmed
        call(32'h3020);
        chk("call count", 32'(ras_count), 1);
        idle(); tick();
        ret(0, 0);
        #1 chk("pred ret_pred", 32'(ret_pred), 1);
        chk("pred npc", npc, 32'h3028);
        tick();
        chk("pred count", 32'(ras_count), 0);
        chk("pred pc_f", pc_f, 32'h3028);
        resolve(32'h3028);
        #1 chk("confirm mispredict", 32'(mispredict), 0);
        tick();
        // predicted return, wrong
        call(32'h3020);
        ret(0, 0); tick();
        resolve(32'h3100);
        #1 chk("wrong mispredict", 32'(mispredict), 1);
        tick();
        chk("wrong pc_f", pc_f, 32'h3100);
        // depth: five calls into four entries
        for (int k = 1; k <= 5; k++) call(32'(k) << 8);
        idle();
        #1 chk("full count", 32'(ras_count), 4);
        for (int j = 0; j < 4; j++) begin
            ret(0, 0);
            #1 chk("pop order", npc, (32'(5 - j) << 8) | 32'h8);
            tick();
            resolve((32'(5 - j) << 8) | 32'h8);
            tick();
        end
        ret(1, 32'h600);
        #1 chk("empty pop npc", npc, 32'h600);
        tick();
        chk("empty pop count", 32'(ras_count), 0);
        ret(0, 0);
        #1 chk("empty ret_stall", 32'(ret_stall), 1);
        tick();
        chk("stall hold pc_f", pc_f, 32'h600);
        // same-cycle call and return replaces the top
        call(32'h700);
        ret(1, 32'h800); is_call = 1; pc_d = 32'h900;
        tick();
        chk("swap count", 32'(ras_count), 1);
        ret(0, 0);
        #1 chk("swap top", npc, 32'h908);
        tick();
        resolve(32'h908); tick();
        // priority: exception beats eret and stall, and clears the prediction
        call(32'hA00);
        ret(0, 0); tick();
        idle(); exc_req = 1; eret_req = 1; stall = 1; epc = 32'h5000;
        #1 chk("exc npc", npc, 32'h4180);
        tick();
        chk("exc pc_f", pc_f, 32'h4180);
        resolve(32'hBAD);
        #1 chk("exc pend cleared", 32'(mispredict), 0);
        tick();
        // reset in the middle of a prediction
        call(32'hB00);
        call(32'hC00);
        ret(0, 0); tick();
        idle(); reset = 1;
        tick();
        chk("mid reset pc_f", pc_f, 32'h3000);
        chk("mid reset count", 32'(ras_count), 0);
        reset = 0;
        resolve(32'hBAD);
        #1 chk("mid reset pend", 32'(mispredict), 0);
        tick();
        idle(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
